radix_converter: RTL

- Parametrised successor to the fixed binary-to-base-3 converter.
- Converts an unsigned binary word to any radix from 2 to 2**DIGIT_W, selected at run time.
- Uses repeated division by the radix, with a built-in sequential restoring divider that produces one quotient bit per cycle (no combinational divider).
- Packs digits LSD-first into a fixed-width digit bus and reports digit count, overflow and illegal-radix status. Sits in the number-transform datapath between the binary source and display/encode stages.

---
 rtl/radix_converter_if.sv | 28 ++
 rtl/radix_converter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/radix_converter_if.sv
// Request/result bundle for radix_converter: operand and radix in, digit bus and status out.
interface radix_converter_if #(
  parameter int IN_W       = 16,
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 11
);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic                          en;
  logic [IN_W-1:0]               bin_in;
  logic [DIGIT_W:0]              radix;
  logic                          busy;
  logic                          done;
  logic [NUM_DIGITS*DIGIT_W-1:0] digits;
  logic [CNT_W-1:0]              digit_count;
  logic                          ovf;
  logic                          err;

  modport slave (
    input  en, bin_in, radix,
    output busy, done, digits, digit_count, ovf, err
  );

  modport master (
    output en, bin_in, radix,
    input  busy, done, digits, digit_count, ovf, err
  );
endinterface

// File: rtl/radix_converter.sv
// Binary to radix-N converter (N = 2..2**DIGIT_W) by repeated division with a
// bit-serial restoring divider; digits are packed LSD-first.
module radix_converter #(
  parameter int IN_W       = 16,
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  radix_converter_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int BIT_W = $clog2(IN_W + 1);

  localparam logic [DIGIT_W:0] RADIX_MIN = {{(DIGIT_W-1){1'b0}}, 2'b10};
  localparam logic [DIGIT_W:0] RADIX_MAX = {1'b1, {DIGIT_W{1'b0}}};
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] LAST_K    = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_STORE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [IN_W-1:0]               r_dividend;
  logic [DIGIT_W:0]              r_divisor;
  logic [DIGIT_W:0]              r_rem;
  logic [BIT_W-1:0]              r_bitcnt;
  logic [CNT_W-1:0]              r_k;
  logic [NUM_DIGITS*DIGIT_W-1:0] r_digits;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_ovf;
  logic                          r_err;

  logic                          w_accept;
  logic                          w_illegal;
  logic [DIGIT_W:0]              w_rem_shift;
  logic                          w_rem_ge;
  logic [DIGIT_W:0]              w_rem_new;
  logic                          w_quot_zero;
  logic                          w_k_last;
  logic                          w_busy_d;
  logic                          w_done_d;

  assign w_accept    = (r_state == S_IDLE) && bus.en;
  assign w_illegal   = (bus.radix < RADIX_MIN) || (bus.radix > RADIX_MAX);
  // Remainder stays below the divisor (<= 2**DIGIT_W), so its top bit is always free to shift into.
  assign w_rem_shift = {r_rem[DIGIT_W-1:0], r_dividend[IN_W-1]};
  assign w_rem_ge    = (w_rem_shift >= r_divisor);
  assign w_rem_new   = w_rem_ge ? (w_rem_shift - r_divisor) : w_rem_shift;
  assign w_quot_zero = (r_dividend == {IN_W{1'b0}});
  assign w_k_last    = (r_k == LAST_K);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.en) begin
          w_next = w_illegal ? S_DONE : S_DIV;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DIV: begin
        if (r_bitcnt == LAST_BIT) begin
          w_next = S_STORE;
        end else begin
          w_next = S_DIV;
        end
      end
      S_STORE: begin
        if (w_quot_zero || w_k_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_DIV;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered flags line up with it
  always_comb begin
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    case (w_next)
      S_IDLE:  begin w_busy_d = 1'b0; w_done_d = 1'b0; end
      S_DIV:   begin w_busy_d = 1'b1; w_done_d = 1'b0; end
      S_STORE: begin w_busy_d = 1'b1; w_done_d = 1'b0; end
      S_DONE:  begin w_busy_d = 1'b1; w_done_d = 1'b1; end
      default: begin w_busy_d = 1'b0; w_done_d = 1'b0; end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_d;
      r_done <= w_done_d;
    end
  end

  // Divider datapath and digit packing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= {IN_W{1'b0}};
      r_divisor  <= {(DIGIT_W+1){1'b0}};
      r_rem      <= {(DIGIT_W+1){1'b0}};
      r_bitcnt   <= {BIT_W{1'b0}};
      r_k        <= {CNT_W{1'b0}};
      r_digits   <= {(NUM_DIGITS*DIGIT_W){1'b0}};
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_dividend <= bus.bin_in;
      r_divisor  <= bus.radix;
      r_rem      <= {(DIGIT_W+1){1'b0}};
      r_bitcnt   <= {BIT_W{1'b0}};
      r_k        <= {CNT_W{1'b0}};
      r_digits   <= {(NUM_DIGITS*DIGIT_W){1'b0}};
      r_ovf      <= 1'b0;
      r_err      <= w_illegal;
    end else if (r_state == S_DIV) begin
      r_rem      <= w_rem_new;
      r_dividend <= {r_dividend[IN_W-2:0], w_rem_ge};
      r_bitcnt   <= r_bitcnt + {{(BIT_W-1){1'b0}}, 1'b1};
    end else if (r_state == S_STORE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (r_k == CNT_W'(i)) begin
          r_digits[i*DIGIT_W +: DIGIT_W] <= r_rem[DIGIT_W-1:0];
        end
      end
      r_k      <= r_k + {{(CNT_W-1){1'b0}}, 1'b1};
      r_rem    <= {(DIGIT_W+1){1'b0}};
      r_bitcnt <= {BIT_W{1'b0}};
      r_ovf    <= !w_quot_zero && w_k_last;
    end else begin
      r_rem <= r_rem;
    end
  end

  // The digit index doubles as the digit count once a digit has been stored
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.digits      = r_digits;
  assign bus.digit_count = r_k;
  assign bus.ovf         = r_ovf;
  assign bus.err         = r_err;

endmodule
